// File: rtl/edid_capture_buffer_if.sv
// rtl/edid_capture_buffer_if.sv - byte-stream, status and readout signals of the EDID capture buffer
interface edid_capture_buffer_if #(
    parameter int ADDR_W = 7
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              busy;
    logic              done;
    logic              header_ok;
    logic              checksum_ok;
    logic              short_err;
    logic              drop_err;
    logic [ADDR_W:0]   byte_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    modport master (
        output start, in_valid, in_data, in_last, rd_addr,
        input  busy, done, header_ok, checksum_ok, short_err, drop_err, byte_count, rd_data
    );

    modport slave (
        input  start, in_valid, in_data, in_last, rd_addr,
        output busy, done, header_ok, checksum_ok, short_err, drop_err, byte_count, rd_data
    );
endinterface

// File: rtl/edid_capture_buffer.sv
// rtl/edid_capture_buffer.sv - captures one EDID block, checks header and checksum, offers registered readout
module edid_capture_buffer #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic                  clk_4MHz,
    input  logic                  rst,
    edid_capture_buffer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        sum_q, sum_d;
    logic              hdr_match_q, hdr_match_d;
    logic              header_ok_q, header_ok_d;
    logic              checksum_ok_q, checksum_ok_d;
    logic              short_err_q, short_err_d;
    logic              drop_err_q, drop_err_d;
    logic [7:0]        rd_data_q;
    logic              mem_we;
    logic              byte_hdr_ok;
    logic              hdr_next;
    logic [7:0]        sum_next;

    logic [7:0] mem [DEPTH];

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        return (idx == 3'd0 || idx == 3'd7) ? 8'h00 : 8'hFF;
    endfunction

    always_ff @(posedge clk_4MHz) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            sum_q         <= '0;
            hdr_match_q   <= 1'b0;
            header_ok_q   <= 1'b0;
            checksum_ok_q <= 1'b0;
            short_err_q   <= 1'b0;
            drop_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            sum_q         <= sum_d;
            hdr_match_q   <= hdr_match_d;
            header_ok_q   <= header_ok_d;
            checksum_ok_q <= checksum_ok_d;
            short_err_q   <= short_err_d;
            drop_err_q    <= drop_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        sum_d         = sum_q;
        hdr_match_d   = hdr_match_q;
        header_ok_d   = header_ok_q;
        checksum_ok_d = checksum_ok_q;
        short_err_d   = short_err_q;
        drop_err_d    = drop_err_q;
        mem_we        = 1'b0;

        // Only the first eight positions take part in the header comparison
        byte_hdr_ok = (int'(wr_ptr_q) >= 8) || (bus.in_data == hdr_byte(wr_ptr_q[2:0]));
        hdr_next    = hdr_match_q & byte_hdr_ok;
        sum_next    = sum_q + bus.in_data;

        if (bus.start) begin
            state_d       = CAPTURE;
            wr_ptr_d      = '0;
            count_d       = '0;
            sum_d         = '0;
            hdr_match_d   = 1'b1;
            header_ok_d   = 1'b0;
            checksum_ok_d = 1'b0;
            short_err_d   = 1'b0;
            drop_err_d    = 1'b0;
        end else if (bus.in_valid) begin
            if (state_q == CAPTURE) begin
                mem_we      = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                count_d     = count_q + 1'b1;
                sum_d       = sum_next;
                hdr_match_d = hdr_next;
                if (int'(wr_ptr_q) == DEPTH - 1) begin
                    state_d       = DONE;
                    header_ok_d   = hdr_next;
                    checksum_ok_d = (sum_next == 8'h00);
                    short_err_d   = 1'b0;
                end else if (bus.in_last) begin
                    // A truncated read only vouches for the header if all eight bytes made it
                    state_d       = DONE;
                    header_ok_d   = hdr_next && (int'(wr_ptr_q) >= 7);
                    checksum_ok_d = 1'b0;
                    short_err_d   = 1'b1;
                end
            end else begin
                drop_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_4MHz) begin
        if (mem_we && !rst) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk_4MHz) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    assign bus.busy        = (state_q == CAPTURE);
    assign bus.done        = (state_q == DONE);
    assign bus.header_ok   = header_ok_q;
    assign bus.checksum_ok = checksum_ok_q;
    assign bus.short_err   = short_err_q;
    assign bus.drop_err    = drop_err_q;
    assign bus.byte_count  = count_q;
    assign bus.rd_data     = rd_data_q;

endmodule

// File: tb/tb_edid_capture_buffer.sv
// tb/tb_edid_capture_buffer.sv - directed self-checking bench for edid_capture_buffer
`timescale 1ns/1ps
module tb_edid_capture_buffer;

    logic clk_4MHz = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    edid_capture_buffer_if #(.ADDR_W(7)) bus ();

    edid_capture_buffer #(.DEPTH(128), .ADDR_W(7)) dut (
        .clk_4MHz (clk_4MHz),
        .rst      (rst),
        .bus      (bus)
    );

    always #125 clk_4MHz = ~clk_4MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] std_byte(input int i, input bit bad);
        if (i == 0 || i == 7) return 8'h00;
        if (i < 8) return (bad && i == 3) ? 8'hFE : 8'hFF;
        if (i == 127) return bad ? 8'h90 : 8'h8F;
        return 8'h01;
    endfunction

    task automatic send(input logic [7:0] d, input bit last, input int gap);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clk_4MHz);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (gap) @(negedge clk_4MHz);
    endtask

    task automatic send_std(input int first, input int n, input bit bad, input bit last_at_end, input int gap);
        for (int i = first; i < n; i++) begin
            send(std_byte(i, bad), last_at_end && (i == n - 1), gap);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk_4MHz);
        bus.start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic d, input logic h, input logic c,
                                input logic s, input logic [7:0] cnt);
        check({tag, ".done"},        bus.done,        d);
        check({tag, ".header_ok"},   bus.header_ok,   h);
        check({tag, ".checksum_ok"}, bus.checksum_ok, c);
        check({tag, ".short_err"},   bus.short_err,   s);
        check({tag, ".byte_count"},  bus.byte_count,  cnt);
        check({tag, ".busy"},        bus.busy,        1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        bus.rd_addr  = '0;
        repeat (2) @(negedge clk_4MHz);

        check("rst.busy",        bus.busy,        1'b0);
        check("rst.done",        bus.done,        1'b0);
        check("rst.header_ok",   bus.header_ok,   1'b0);
        check("rst.checksum_ok", bus.checksum_ok, 1'b0);
        check("rst.short_err",   bus.short_err,   1'b0);
        check("rst.drop_err",    bus.drop_err,    1'b0);
        check("rst.byte_count",  bus.byte_count,  8'd0);
        check("rst.rd_data",     bus.rd_data,     8'h00);
        rst = 1'b0;
        @(negedge clk_4MHz);

        send(8'h55, 1'b0, 0);
        check("idle_drop.drop_err", bus.drop_err, 1'b1);
        check("idle_drop.busy",     bus.busy,     1'b0);
        pulse_start();
        check("start_clr.drop_err", bus.drop_err, 1'b0);
        check("start_clr.busy",     bus.busy,     1'b1);

        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        @(negedge clk_4MHz);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("start_wins.byte_count", bus.byte_count, 8'd0);
        check("start_wins.drop_err",   bus.drop_err,   1'b0);

        send_std(0, 128, 1'b0, 1'b1, 0);
        check_result("full", 1'b1, 1'b1, 1'b1, 1'b0, 8'd128);
        bus.rd_addr = 7'h7F;
        @(negedge clk_4MHz);
        check("full.rd_7f", bus.rd_data, 8'h8F);
        bus.rd_addr = 7'h05;
        @(negedge clk_4MHz);
        check("full.rd_05", bus.rd_data, 8'hFF);

        pulse_start();
        check("restart.done", bus.done, 1'b0);
        send_std(0, 128, 1'b1, 1'b1, 0);
        check_result("badhdr", 1'b1, 1'b0, 1'b1, 1'b0, 8'd128);
        bus.rd_addr = 7'h03;
        @(negedge clk_4MHz);
        check("badhdr.rd_03", bus.rd_data, 8'hFE);

        pulse_start();
        send_std(0, 20, 1'b0, 1'b1, 0);
        check_result("short20", 1'b1, 1'b1, 1'b0, 1'b1, 8'd20);

        pulse_start();
        send_std(0, 5, 1'b0, 1'b1, 0);
        check_result("short5", 1'b1, 1'b0, 1'b0, 1'b1, 8'd5);

        send(8'h12, 1'b0, 0);
        check("done_drop.drop_err", bus.drop_err, 1'b1);

        pulse_start();
        for (int i = 0; i < 50; i++) send(8'h33, 1'b0, 0);
        check("abort.byte_count", bus.byte_count, 8'd50);
        pulse_start();
        check("abort.restart_count", bus.byte_count, 8'd0);
        send_std(0, 128, 1'b0, 1'b1, 0);
        check_result("abort", 1'b1, 1'b1, 1'b1, 1'b0, 8'd128);

        pulse_start();
        for (int i = 0; i < 50; i++) send(8'h44, 1'b0, 0);
        pulse_start();
        rst = 1'b1;
        @(negedge clk_4MHz);
        rst = 1'b0;
        check("midrst.busy",        bus.busy,        1'b0);
        check("midrst.done",        bus.done,        1'b0);
        check("midrst.header_ok",   bus.header_ok,   1'b0);
        check("midrst.checksum_ok", bus.checksum_ok, 1'b0);
        check("midrst.short_err",   bus.short_err,   1'b0);
        check("midrst.drop_err",    bus.drop_err,    1'b0);
        check("midrst.byte_count",  bus.byte_count,  8'd0);
        check("midrst.rd_data",     bus.rd_data,     8'h00);
        send(8'h66, 1'b0, 0);
        check("midrst.late_drop", bus.drop_err, 1'b1);

        pulse_start();
        send_std(0, 8, 1'b0, 1'b0, 40);
        check("gap.busy_mid",  bus.busy,       1'b1);
        check("gap.count_mid", bus.byte_count, 8'd8);
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 7'(a);
            @(negedge clk_4MHz);
            check($sformatf("gap.rd_%0d", a), bus.rd_data, std_byte(a, 1'b0));
        end
        send_std(8, 128, 1'b0, 1'b1, 40);
        check_result("gap", 1'b1, 1'b1, 1'b1, 1'b0, 8'd128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edid_capture_buffer.md
Name: edid_capture_buffer

Overview:
- Downstream consumer of the DDC/I2C read master: takes the byte stream it reads from the display (device 0x50) and stores one 128-byte EDID block in local RAM.
- Checks the 8-byte EDID header and the block checksum while bytes arrive.
- Provides a registered random-read port for the LED/button display logic.
- Lives in the clk_4MHz domain next to the I2C master; the master's read bytes are synchronised to clk_4MHz before this block.

Parameters:
- DEPTH, 128, bytes per capture (EDID block size); power of two, 8..256.
- ADDR_W, 7, log2(DEPTH); width of rd_addr and wr pointer.

Ports:
- clk_4MHz  in  1  block clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse: clear status and arm a new capture.
- in_valid  in  1  single-cycle pulse: in_data holds one received byte.
- in_data  in  8  received byte, MSB first as read off SDA.
- in_last  in  1  qualified by in_valid: this is the final byte (master sent NACK/STOP).
- busy  out  1  high while in CAPTURE.
- done  out  1  high in DONE; held until start or rst.
- header_ok  out  1  first 8 bytes were 00 FF FF FF FF FF FF 00; valid when done.
- checksum_ok  out  1  sum of all DEPTH bytes mod 256 == 0; valid when done.
- short_err  out  1  in_last arrived before DEPTH bytes; valid when done.
- drop_err  out  1  sticky: in_valid seen while not in CAPTURE.
- byte_count  out  ADDR_W+1  bytes stored in current/last capture, 0..DEPTH.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  8  mem[rd_addr], registered, 1-cycle latency.

Behaviour:
- Reset: state IDLE. busy, done, header_ok, checksum_ok, short_err, drop_err, byte_count, rd_data = 0. RAM contents are not cleared.
- States:
  - IDLE: start -> CAPTURE.
  - CAPTURE: busy=1; accepts bytes.
  - DONE: done=1; start -> CAPTURE.
- Entering CAPTURE (start in any state):
  - wr_ptr=0, byte_count=0, sum=0.
  - hdr_match=1; done and all *_ok/err flags cleared, including drop_err.
- Accepted byte (CAPTURE and in_valid):
  - mem[wr_ptr]<=in_data; wr_ptr+1; byte_count+1.
  - sum<=sum+in_data, 8-bit wrap.
  - If wr_ptr<8 and in_data != header[wr_ptr]: hdr_match<=0.
- Completion (checked on the accepting cycle, flags registered the same edge as the state change):
  - Byte is number DEPTH (wr_ptr==DEPTH-1): -> DONE next cycle. header_ok=hdr_match including this byte; checksum_ok=(final sum==0); short_err=0.
  - in_last before byte DEPTH: -> DONE. short_err=1; checksum_ok=0; header_ok=hdr_match only if byte_count>=8, else 0.
  - in_last on byte DEPTH itself: normal completion, short_err=0.
- No backpressure; the block always accepts in CAPTURE.
- in_valid outside CAPTURE: data ignored, drop_err<=1.
- start and in_valid in the same cycle: start wins. The byte is discarded and drop_err is not set.
- start during CAPTURE: abort. Restart from wr_ptr 0; old partial data is overwritten as new bytes arrive.
- rd_data<=mem[rd_addr] every cycle, in any state.
  - Reading an address being written in the same cycle returns the old contents (read-before-write).
  - Readout is legal during capture.
- rst mid-capture: immediate return to IDLE with all outputs per reset; a later in_valid sets drop_err.
- byte_count saturates at DEPTH; the wr pointer never wraps within a capture.

Test Plan:
- rst, start, 128 bytes: header 00 FF FF FF FF FF FF 00, bytes 8..126 = 0x01, byte 127 = 0x8F, in_last on byte 127 -> done=1, header_ok=1, checksum_ok=1, short_err=0, byte_count=128; rd_addr=0x7F gives rd_data=0x8F one cycle later.
- Same stream with byte 3 = 0xFE and byte 127 = 0x90 -> header_ok=0, checksum_ok=1.
- start, 20 header-correct bytes, in_last on byte 20 -> done=1, short_err=1, checksum_ok=0, header_ok=1, byte_count=20; repeat with in_last on byte 5 -> header_ok=0.
- in_valid before any start -> drop_err=1; next start -> drop_err=0. start coincident with in_valid(0xAA) -> byte_count=0, drop_err=0.
- start, 50 bytes, start again, 128 valid bytes -> byte_count=128, checksum from second stream only; start at byte 50 of a capture then rst -> all outputs 0, state IDLE.
- Gaps: in_valid every 40 cycles vs back-to-back -> identical flags; read mem[0..7] during capture returns bytes already written.
